mem_port_arbiter: RTL and testbench

Shares the single backing-memory port between the instruction-fetch cache and the data cache. Each cache raises a miss/write-through request. The arbiter grants one requester with two-way round-robin, runs the memory handshake, watches for a stalled memory, and returns one response pulse to the granted side. It sits between the two cacheline instances and main memory.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter_rr_arb2.sv | 34 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing helpers for the two-port memory arbiter.
// Grant encoding doubles as the round-robin pointer value.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

    typedef enum logic {GRANT_I, GRANT_D} grant_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned CNT_W_DEFAULT   = $clog2(TIMEOUT_DEFAULT + 1);

    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of cache-side request/response and memory-side handshake signals.
// master = cache/memory environment, slave = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int unsigned WIDTH = 32
);

    logic             i_req_i;
    logic [WIDTH-1:0] i_addr_i;
    logic [WIDTH-1:0] i_rdata_o;
    logic             i_resp_o;

    logic             d_req_i;
    logic             d_we_i;
    logic             d_byte_op_i;
    logic [WIDTH-1:0] d_addr_i;
    logic [WIDTH-1:0] d_wdata_i;
    logic [WIDTH-1:0] d_rdata_o;
    logic             d_resp_o;

    logic             mem_req_o;
    logic             mem_we_o;
    logic             mem_byte_op_o;
    logic [WIDTH-1:0] mem_addr_o;
    logic [WIDTH-1:0] mem_wdata_o;
    logic [WIDTH-1:0] mem_rdata_i;
    logic             mem_ready_i;

    logic             timeout_o;

    modport master (
        output i_req_i, i_addr_i,
        output d_req_i, d_we_i, d_byte_op_i, d_addr_i, d_wdata_i,
        output mem_rdata_i, mem_ready_i,
        input  i_rdata_o, i_resp_o, d_rdata_o, d_resp_o,
        input  mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wdata_o,
        input  timeout_o
    );

    modport slave (
        input  i_req_i, i_addr_i,
        input  d_req_i, d_we_i, d_byte_op_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i, mem_ready_i,
        output i_rdata_o, i_resp_o, d_rdata_o, d_resp_o,
        output mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wdata_o,
        output timeout_o
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_grant also identifies the side currently
// owning the memory port, since it is updated on the grant edge.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_inst,
    input  logic   req_data,
    input  logic   update,
    output logic   any_req,
    output grant_t grant,
    output grant_t last_grant
);

    always_comb begin
        any_req = req_inst | req_data;
        grant   = GRANT_I;
        if (req_inst && req_data) begin
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (req_data) begin
            grant = GRANT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_I;
        end else if (update) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction and data caches: round-robin
// grant, registered memory handshake with stall timeout, one response pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    grant_t           grant;
    grant_t           owner;
    logic             any_req;
    logic             grant_en;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] i_rdata_q;
    logic [WIDTH-1:0] d_rdata_q;
    logic             we_q;
    logic             byte_op_q;
    logic             timeout_q;

    rr_arb2 u_rr (
        .clk        (clk_i),
        .rst        (rst_i),
        .req_inst   (bus.i_req_i),
        .req_data   (bus.d_req_i),
        .update     (grant_en),
        .any_req    (any_req),
        .grant      (grant),
        .last_grant (owner)
    );

    assign cnt_hit = (cnt == CNT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready wins over the limit in the same cycle, so both exit ISSUE together.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   if (bus.mem_ready_i || cnt_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_en          = (state == IDLE) && any_req;
        bus.mem_req_o     = (state == ISSUE);
        bus.i_resp_o      = (state == RESP) && (owner == GRANT_I);
        bus.d_resp_o      = (state == RESP) && (owner == GRANT_D);
        bus.mem_addr_o    = addr_q;
        bus.mem_wdata_o   = wdata_q;
        bus.mem_we_o      = we_q;
        bus.mem_byte_op_o = byte_op_q;
        bus.i_rdata_o     = i_rdata_q;
        bus.d_rdata_o     = d_rdata_q;
        bus.timeout_o     = timeout_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            byte_op_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cnt <= '0;
                        if (grant == GRANT_D) begin
                            addr_q    <= bus.d_addr_i;
                            wdata_q   <= bus.d_wdata_i;
                            we_q      <= bus.d_we_i;
                            byte_op_q <= bus.d_byte_op_i;
                        end else begin
                            addr_q    <= bus.i_addr_i;
                            wdata_q   <= '0;
                            we_q      <= 1'b0;
                            byte_op_q <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready_i) begin
                        if (!we_q) begin
                            if (owner == GRANT_D) d_rdata_q <= bus.mem_rdata_i;
                            else                  i_rdata_q <= bus.mem_rdata_i;
                        end
                    end else if (cnt_hit) begin
                        timeout_q <= 1'b1;
                        if (!we_q) begin
                            if (owner == GRANT_D) d_rdata_q <= '0;
                            else                  i_rdata_q <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: default-TIMEOUT instance for the
// handshake/arbitration scenarios, TIMEOUT=4 instance for the stall limit.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(32)) bus  ();
    mem_port_arbiter_if #(.WIDTH(32)) bus2 ();

    mem_port_arbiter #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    mem_port_arbiter #(.WIDTH(32), .TIMEOUT(4)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req_i      = 1'b0;  bus.i_addr_i    = '0;
        bus.d_req_i      = 1'b0;  bus.d_we_i      = 1'b0;
        bus.d_byte_op_i  = 1'b0;  bus.d_addr_i    = '0;
        bus.d_wdata_i    = '0;    bus.mem_rdata_i = '0;
        bus.mem_ready_i  = 1'b0;
        bus2.i_req_i     = 1'b0;  bus2.i_addr_i   = '0;
        bus2.d_req_i     = 1'b0;  bus2.d_we_i     = 1'b0;
        bus2.d_byte_op_i = 1'b0;  bus2.d_addr_i   = '0;
        bus2.d_wdata_i   = '0;    bus2.mem_rdata_i = '0;
        bus2.mem_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h exp=0", bus.mem_req_o); end
        total++; if (bus.mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%0h exp=0", bus.mem_addr_o); end
        total++; if (bus.mem_wdata_o !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%0h exp=0", bus.mem_wdata_o); end
        total++; if ({bus.mem_we_o, bus.mem_byte_op_o} !== 2'b00) begin bad++; $display("FAIL reset_we_byte got=%0b exp=00", {bus.mem_we_o, bus.mem_byte_op_o}); end
        total++; if ({bus.i_resp_o, bus.d_resp_o} !== 2'b00) begin bad++; $display("FAIL reset_resp got=%0b exp=00", {bus.i_resp_o, bus.d_resp_o}); end
        total++; if (bus.i_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_i_rdata got=%0h exp=0", bus.i_rdata_o); end
        total++; if (bus.d_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_d_rdata got=%0h exp=0", bus.d_rdata_o); end
        total++; if ({bus.timeout_o, bus2.timeout_o} !== 2'b00) begin bad++; $display("FAIL reset_timeout got=%0b exp=00", {bus.timeout_o, bus2.timeout_o}); end
    endtask

    task automatic test_single_read();
        bus.i_req_i     = 1'b1;
        bus.i_addr_i    = 32'h40;
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'hDEADBEEF;
        tick();
        total++; if (bus.mem_req_o !== 1'b1) begin bad++; $display("FAIL single_mem_req got=%0h exp=1", bus.mem_req_o); end
        total++; if (bus.mem_addr_o !== 32'h40) begin bad++; $display("FAIL single_addr got=%0h exp=40", bus.mem_addr_o); end
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL single_we_issue got=%0h exp=0", bus.mem_we_o); end
        total++; if (bus.i_resp_o !== 1'b0) begin bad++; $display("FAIL single_early_resp got=%0h exp=0", bus.i_resp_o); end
        tick();
        total++; if (bus.i_resp_o !== 1'b1) begin bad++; $display("FAIL single_resp got=%0h exp=1", bus.i_resp_o); end
        total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL single_req_fall got=%0h exp=0", bus.mem_req_o); end
        total++; if (bus.i_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%0h exp=deadbeef", bus.i_rdata_o); end
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL single_we_resp got=%0h exp=0", bus.mem_we_o); end
        bus.i_req_i     = 1'b0;
        bus.mem_ready_i = 1'b0;
        tick();
        total++; if (bus.i_resp_o !== 1'b0) begin bad++; $display("FAIL single_resp_one_cycle got=%0h exp=0", bus.i_resp_o); end
    endtask

    task automatic test_tie_from_reset();
        do_reset();
        bus.d_req_i     = 1'b1;
        bus.d_we_i      = 1'b1;
        bus.d_addr_i    = 32'h80;
        bus.d_wdata_i   = 32'h12345678;
        bus.i_req_i     = 1'b1;
        bus.i_addr_i    = 32'h44;
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'hAAAA5555;
        tick();
        total++; if (bus.mem_addr_o !== 32'h80) begin bad++; $display("FAIL tie_first_addr got=%0h exp=80", bus.mem_addr_o); end
        total++; if (bus.mem_we_o !== 1'b1) begin bad++; $display("FAIL tie_first_we got=%0h exp=1", bus.mem_we_o); end
        total++; if (bus.mem_wdata_o !== 32'h12345678) begin bad++; $display("FAIL tie_wdata got=%0h exp=12345678", bus.mem_wdata_o); end
        tick();
        total++; if ({bus.d_resp_o, bus.i_resp_o} !== 2'b10) begin bad++; $display("FAIL tie_d_resp got=%0b exp=10", {bus.d_resp_o, bus.i_resp_o}); end
        total++; if (bus.d_rdata_o !== 32'h0) begin bad++; $display("FAIL tie_d_rdata_kept got=%0h exp=0", bus.d_rdata_o); end
        bus.d_req_i = 1'b0;
        tick();
        tick();
        total++; if (bus.mem_addr_o !== 32'h44) begin bad++; $display("FAIL tie_second_addr got=%0h exp=44", bus.mem_addr_o); end
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL tie_second_we got=%0h exp=0", bus.mem_we_o); end
        tick();
        total++; if ({bus.d_resp_o, bus.i_resp_o} !== 2'b01) begin bad++; $display("FAIL tie_i_resp got=%0b exp=01", {bus.d_resp_o, bus.i_resp_o}); end
        total++; if (bus.i_rdata_o !== 32'hAAAA5555) begin bad++; $display("FAIL tie_i_rdata got=%0h exp=aaaa5555", bus.i_rdata_o); end
        bus.i_req_i     = 1'b0;
        bus.mem_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_alternate();
        logic [3:0] exp_d;
        exp_d = 4'b0101;
        bus.d_req_i     = 1'b1;
        bus.d_we_i      = 1'b0;
        bus.d_addr_i    = 32'h100;
        bus.i_req_i     = 1'b1;
        bus.i_addr_i    = 32'h200;
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'h11112222;
        for (int n = 0; n < 4; n++) begin
            tick();
            total++; if (bus.mem_addr_o !== (exp_d[n] ? 32'h100 : 32'h200)) begin bad++; $display("FAIL alt_addr_%0d got=%0h exp=%0h", n, bus.mem_addr_o, exp_d[n] ? 32'h100 : 32'h200); end
            tick();
            total++; if ({bus.d_resp_o, bus.i_resp_o} !== {exp_d[n], ~exp_d[n]}) begin bad++; $display("FAIL alt_resp_%0d got=%0b exp=%0b", n, {bus.d_resp_o, bus.i_resp_o}, {exp_d[n], ~exp_d[n]}); end
            tick();
        end
        bus.d_req_i     = 1'b0;
        bus.i_req_i     = 1'b0;
        bus.mem_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        int hi;
        hi = 0;
        bus.i_req_i     = 1'b1;
        bus.i_addr_i    = 32'h48;
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = 32'hCAFEF00D;
        tick();
        for (int k = 0; k < 6; k++) begin
            if (bus.mem_req_o === 1'b1) hi++;
            total++; if (bus.mem_addr_o !== 32'h48 || bus.i_resp_o !== 1'b0) begin bad++; $display("FAIL wait_stable_%0d got=%0h/%0h exp=48/0", k, bus.mem_addr_o, bus.i_resp_o); end
            if (k == 5) bus.mem_ready_i = 1'b1;
            tick();
        end
        total++; if (hi !== 6) begin bad++; $display("FAIL wait_req_cycles got=%0d exp=6", hi); end
        total++; if ({bus.i_resp_o, bus.mem_req_o} !== 2'b10) begin bad++; $display("FAIL wait_resp got=%0b exp=10", {bus.i_resp_o, bus.mem_req_o}); end
        total++; if (bus.i_rdata_o !== 32'hCAFEF00D) begin bad++; $display("FAIL wait_rdata got=%0h exp=cafef00d", bus.i_rdata_o); end
        bus.i_req_i     = 1'b0;
        bus.mem_ready_i = 1'b0;
        tick();
        total++; if ({bus.i_resp_o, bus.mem_req_o} !== 2'b00) begin bad++; $display("FAIL wait_after got=%0b exp=00", {bus.i_resp_o, bus.mem_req_o}); end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        bus.d_req_i     = 1'b1;
        bus.d_we_i      = 1'b0;
        bus.d_addr_i    = 32'h180;
        bus.i_req_i     = 1'b1;
        bus.i_addr_i    = 32'h280;
        bus.mem_ready_i = 1'b0;
        tick();
        total++; if (bus.mem_addr_o !== 32'h180) begin bad++; $display("FAIL rstmid_first_addr got=%0h exp=180", bus.mem_addr_o); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({bus.mem_req_o, bus.i_resp_o, bus.d_resp_o} !== 3'b000) begin bad++; $display("FAIL rstmid_idle got=%0b exp=000", {bus.mem_req_o, bus.i_resp_o, bus.d_resp_o}); end
        tick();
        total++; if (bus.mem_addr_o !== 32'h180) begin bad++; $display("FAIL rstmid_regrant got=%0h exp=180", bus.mem_addr_o); end
        total++; if (bus.mem_req_o !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%0h exp=1", bus.mem_req_o); end
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'h0BADF00D;
        tick();
        total++; if ({bus.d_resp_o, bus.i_resp_o} !== 2'b10) begin bad++; $display("FAIL rstmid_resp got=%0b exp=10", {bus.d_resp_o, bus.i_resp_o}); end
        total++; if (bus.d_rdata_o !== 32'h0BADF00D) begin bad++; $display("FAIL rstmid_rdata got=%0h exp=badf00d", bus.d_rdata_o); end
        bus.d_req_i     = 1'b0;
        bus.i_req_i     = 1'b0;
        bus.mem_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_ready_at_limit();
        int hi;
        hi = 0;
        bus2.d_req_i     = 1'b1;
        bus2.d_we_i      = 1'b0;
        bus2.d_addr_i    = 32'h300;
        bus2.mem_ready_i = 1'b0;
        bus2.mem_rdata_i = 32'h5A5A5A5A;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (bus2.mem_req_o === 1'b1) hi++;
            if (k == 3) bus2.mem_ready_i = 1'b1;
            tick();
        end
        total++; if (hi !== 4) begin bad++; $display("FAIL limit_req_cycles got=%0d exp=4", hi); end
        total++; if (bus2.d_resp_o !== 1'b1) begin bad++; $display("FAIL limit_resp got=%0h exp=1", bus2.d_resp_o); end
        total++; if (bus2.timeout_o !== 1'b0) begin bad++; $display("FAIL limit_no_timeout got=%0h exp=0", bus2.timeout_o); end
        total++; if (bus2.d_rdata_o !== 32'h5A5A5A5A) begin bad++; $display("FAIL limit_rdata got=%0h exp=5a5a5a5a", bus2.d_rdata_o); end
        bus2.d_req_i     = 1'b0;
        bus2.mem_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int hi;
        int pulses;
        hi     = 0;
        pulses = 0;
        bus2.d_req_i     = 1'b1;
        bus2.d_we_i      = 1'b0;
        bus2.d_addr_i    = 32'h304;
        bus2.mem_ready_i = 1'b0;
        bus2.mem_rdata_i = 32'hFFFFFFFF;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (bus2.mem_req_o === 1'b1) hi++;
            if (k == 3) begin
                total++; if (bus2.timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_early got=%0h exp=0", bus2.timeout_o); end
            end
            tick();
        end
        total++; if (hi !== 4) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=4", hi); end
        total++; if (bus2.mem_req_o !== 1'b0) begin bad++; $display("FAIL timeout_req_fall got=%0h exp=0", bus2.mem_req_o); end
        total++; if (bus2.timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%0h exp=1", bus2.timeout_o); end
        total++; if (bus2.d_rdata_o !== 32'h0) begin bad++; $display("FAIL timeout_rdata got=%0h exp=0", bus2.d_rdata_o); end
        if (bus2.d_resp_o === 1'b1) pulses++;
        bus2.d_req_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus2.d_resp_o === 1'b1) pulses++;
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
        total++; if (bus2.timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%0h exp=1", bus2.timeout_o); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_from_reset();
        test_alternate();
        test_wait_states();
        test_reset_mid_issue();
        test_ready_at_limit();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
